// File: rtl/stream_pkg.sv
// Shared types and constants for the stream framing blocks.
package stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PAY  = 2'd1,
        CSUM = 2'd2
    } framer_state_e;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

endpackage : stream_pkg

// File: rtl/stream_framer.sv
// Wraps a byte stream into frames of HEADER, PAYLOAD_LEN payload beats and an XOR checksum.
// All framed beats leave through one registered output stage with valid/ready flow control.
module stream_framer
    import stream_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    PAYLOAD_LEN = 4,
    parameter logic [DATA_WIDTH-1:0] HEADER      = DATA_WIDTH'(HEADER_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [15:0]           frame_count,
    output logic                  busy
);

    localparam int               CNT_W    = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_LEN - 1);

    framer_state_e         state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] csum_q;
    logic [DATA_WIDTH-1:0] csum_d;
    logic                  m_valid_q;
    logic [DATA_WIDTH-1:0] m_data_q;
    logic                  m_last_q;
    logic [15:0]           frame_count_q;
    logic                  load;

    // The output register may take a new beat when it is empty or being drained.
    assign load    = !m_valid_q || m_ready;
    assign s_ready = (state_q == PAY) && load;
    assign csum_d  = csum_q ^ s_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            csum_q        <= '0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            m_last_q      <= 1'b0;
            frame_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        if (s_valid) begin
                            m_valid_q <= 1'b1;
                            m_data_q  <= HEADER;
                            m_last_q  <= 1'b0;
                            cnt_q     <= '0;
                            csum_q    <= '0;
                            state_q   <= PAY;
                        end else begin
                            m_valid_q <= 1'b0;
                        end
                    end
                end
                PAY: begin
                    if (load) begin
                        if (s_valid) begin
                            m_valid_q <= 1'b1;
                            m_data_q  <= s_data;
                            m_last_q  <= 1'b0;
                            csum_q    <= csum_d;
                            cnt_q     <= cnt_q + CNT_W'(1);
                            if (cnt_q == LAST_IDX) begin
                                state_q <= CSUM;
                            end
                        end else begin
                            m_valid_q <= 1'b0;
                        end
                    end
                end
                CSUM: begin
                    if (load) begin
                        m_valid_q     <= 1'b1;
                        m_data_q      <= csum_q;
                        m_last_q      <= 1'b1;
                        frame_count_q <= frame_count_q + 16'd1;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_last      = m_last_q;
    assign frame_count = frame_count_q;
    assign busy        = (state_q != IDLE) || m_valid_q;

endmodule : stream_framer
